// File: rtl/memread_check_main.sv
// memread_check_main: command-driven memory scan and checker.
//
// Pops a word count N from the input channel and reads memory addresses 0..N-1.
// Each returned word adds the sum of its lanes to a running total. A word whose lane 0
// differs from its address raises a saturating error count. Three words are then
// pushed to the output channel, in this order:
//   - the cycle count,
//   - the lane sum,
//   - the error count.
//
// Ports:
//   CLK, RST    clock and asynchronous active-high reset
//   mem_addr    memory read address (held outside the read phase)
//   mem_q       read data for the previous cycle's mem_addr, SIMD_WIDTH lanes of W_D bits
//   comm_d      channel enqueue data (holds its last value when not enqueuing)
//   comm_enq    channel enqueue strobe
//   comm_full   channel full
//   comm_q      channel dequeue data, valid the cycle after comm_deq
//   comm_deq    channel dequeue strobe
//   comm_empty  channel empty
module memread_check_main #(
  parameter int unsigned SIMD_WIDTH = 1,
  parameter int unsigned W_D        = 32,
  parameter int unsigned W_A        = 12,
  parameter int unsigned W_COMM_D   = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  output logic [W_A-1:0]            mem_addr,
  input  logic [W_D*SIMD_WIDTH-1:0] mem_q,
  output logic [W_COMM_D-1:0]       comm_d,
  output logic                      comm_enq,
  input  logic                      comm_full,
  input  logic [W_COMM_D-1:0]       comm_q,
  output logic                      comm_deq,
  input  logic                      comm_empty
);

  typedef enum logic [2:0] {
    StIdle,
    StDeq,
    StLatch,
    StRead,
    StDrain,
    StSendCyc,
    StSendSum,
    StSendErr
  } state_e;

  localparam logic [W_A:0] NMax   = (W_A + 1)'(1) << W_A;
  localparam logic [W_A:0] IdxOne = (W_A + 1)'(1);

  state_e              state_q, state_d;
  logic [W_A:0]        n_q;
  logic [W_A:0]        idx_q;
  logic [W_A-1:0]      addr_hold_q;
  logic                vld_q;
  logic [W_A-1:0]      chk_addr_q;
  logic [W_COMM_D-1:0] sum_q;
  logic [W_COMM_D-1:0] err_q;
  logic [W_COMM_D-1:0] cyc_q;
  logic [W_COMM_D-1:0] comm_d_q;
  logic [W_COMM_D-1:0] send_val;
  logic [W_COMM_D-1:0] lane_sum;
  logic [W_A:0]        n_raw;
  logic [W_A:0]        n_clamp;
  logic                lane0_bad;

  // Only the low W_A+1 command bits carry the count.
  logic unused_comm_q;
  assign unused_comm_q = ^comm_q[W_COMM_D-1:W_A+1];

  assign n_raw   = comm_q[W_A:0];
  assign n_clamp = (n_raw > NMax) ? NMax : n_raw;

  always_comb begin
    lane_sum = '0;
    for (int unsigned i = 0; i < SIMD_WIDTH; i++) begin
      lane_sum = lane_sum + W_COMM_D'(mem_q[i*W_D +: W_D]);
    end
  end

  assign lane0_bad = (mem_q[W_D-1:0] != W_D'(chk_addr_q));

  // The live read index is shown only during READ; otherwise the last issued address holds.
  assign mem_addr = (state_q == StRead) ? idx_q[W_A-1:0] : addr_hold_q;
  assign comm_d   = send_val;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    comm_deq = 1'b0;
    comm_enq = 1'b0;
    send_val = comm_d_q;
    unique case (state_q)
      StIdle: begin
        if (!comm_empty) state_d = StDeq;
      end
      StDeq: begin
        comm_deq = 1'b1;
        state_d  = StLatch;
      end
      StLatch: begin
        state_d = (n_clamp != '0) ? StRead : StSendCyc;
      end
      StRead: begin
        if ((idx_q + IdxOne) == n_q) state_d = StDrain;
      end
      StDrain: begin
        state_d = StSendCyc;
      end
      StSendCyc: begin
        if (!comm_full) begin
          comm_enq = 1'b1;
          send_val = cyc_q;
          state_d  = StSendSum;
        end
      end
      StSendSum: begin
        if (!comm_full) begin
          comm_enq = 1'b1;
          send_val = sum_q;
          state_d  = StSendErr;
        end
      end
      StSendErr: begin
        if (!comm_full) begin
          comm_enq = 1'b1;
          send_val = err_q;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      n_q         <= '0;
      idx_q       <= '0;
      addr_hold_q <= '0;
      vld_q       <= 1'b0;
      chk_addr_q  <= '0;
      sum_q       <= '0;
      err_q       <= '0;
      cyc_q       <= '0;
      comm_d_q    <= '0;
    end else begin
      comm_d_q <= send_val;
      // Data for an address issued in READ returns one cycle later; tag it with its address.
      vld_q    <= (state_q == StRead);
      if (state_q == StRead) chk_addr_q <= idx_q[W_A-1:0];

      unique case (state_q)
        StIdle: begin
          cyc_q <= '0;
        end
        StLatch: begin
          n_q   <= n_clamp;
          idx_q <= '0;
          sum_q <= '0;
          err_q <= '0;
          cyc_q <= cyc_q + 1'b1;
        end
        StRead: begin
          idx_q       <= idx_q + IdxOne;
          addr_hold_q <= idx_q[W_A-1:0];
          cyc_q       <= cyc_q + 1'b1;
        end
        StDrain: begin
          cyc_q <= cyc_q + 1'b1;
        end
        default: ;
      endcase

      // vld_q is never set in LATCH, so this cannot collide with the clears above.
      if (vld_q) begin
        sum_q <= sum_q + lane_sum;
        if (lane0_bad && (err_q != '1)) err_q <= err_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memread_check_main.sv
module tb_memread_check_main;

  logic        CLK;
  logic        RST;
  logic [11:0] mem_addr;
  logic [31:0] mem_q;
  logic [31:0] comm_d;
  logic        comm_enq;
  logic        comm_full;
  logic [31:0] comm_q;
  logic        comm_deq;
  logic        comm_empty;

  memread_check_main #(
    .SIMD_WIDTH(1),
    .W_D(32),
    .W_A(12),
    .W_COMM_D(32)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .mem_addr(mem_addr),
    .mem_q(mem_q),
    .comm_d(comm_d),
    .comm_enq(comm_enq),
    .comm_full(comm_full),
    .comm_q(comm_q),
    .comm_deq(comm_deq),
    .comm_empty(comm_empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: one-cycle read latency.
  logic [31:0] mem [0:4095];
  always @(posedge CLK) mem_q <= mem[mem_addr];

  // Command channel: bench pushes, DUT pops.
  logic [31:0] cmd_mem [0:15];
  int push_cnt = 0;
  int pop_cnt  = 0;
  assign comm_empty = (push_cnt == pop_cnt);
  initial comm_q = '0;
  always @(posedge CLK) begin
    if (comm_deq) begin
      comm_q  <= cmd_mem[pop_cnt];
      pop_cnt <= pop_cnt + 1;
    end
  end

  // Report channel capture.
  logic [31:0] rx [0:63];
  int rx_cnt = 0;
  always @(posedge CLK) begin
    if (comm_enq) begin
      rx[rx_cnt] <= comm_d;
      rx_cnt     <= rx_cnt + 1;
    end
  end

  int overlap_cnt = 0;
  always @(negedge CLK) if (comm_enq && comm_deq) overlap_cnt++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_cmd(input logic [31:0] v);
    cmd_mem[push_cnt] = v;
    push_cnt++;
  endtask

  task automatic wait_deq(input string tag);
    bit got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge CLK);
      if (comm_deq) got = 1;
    end
    check({tag, "_deq_seen"}, 32'(got), 32'd1);
  endtask

  task automatic wait_rx(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && rx_cnt < target; i++) @(negedge CLK);
    check({tag, "_rx_count"}, 32'(rx_cnt), 32'(target));
  endtask

  // Issue one command, optionally check the first n_addr read addresses, then the report.
  task automatic do_cmd(input string tag, input logic [31:0] n, input int n_addr,
                        input logic [31:0] exp_c, input logic [31:0] exp_s,
                        input logic [31:0] exp_e, input int budget);
    int base = rx_cnt;
    push_cmd(n);
    if (n_addr > 0) begin
      wait_deq(tag);
      @(negedge CLK);  // LATCH
      for (int i = 0; i < n_addr; i++) begin
        @(negedge CLK);
        check({tag, "_addr"}, 32'(mem_addr), 32'(i));
      end
    end
    wait_rx(tag, base + 3, budget);
    check({tag, "_cyc"}, rx[base], exp_c);
    check({tag, "_sum"}, rx[base+1], exp_s);
    check({tag, "_err"}, rx[base+2], exp_e);
  endtask

  initial begin
    int base;
    bit seen;
    for (int i = 0; i < 4096; i++) mem[i] = 32'(i);
    RST       = 1'b1;
    comm_full = 1'b0;
    #1;
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_comm_d", comm_d, 32'd0);
    check("reset_comm_enq", 32'(comm_enq), 32'd0);
    check("reset_comm_deq", 32'(comm_deq), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Basic scan: addresses 0..3, report 6, 6, 0.
    do_cmd("n4", 32'd4, 4, 32'd6, 32'd6, 32'd0, 100);

    // N=0: no reads, mem_addr keeps the last address (3).
    do_cmd("n0", 32'd0, 0, 32'd1, 32'd0, 32'd0, 100);
    check("n0_addr_hold", 32'(mem_addr), 32'd3);

    // Back-pressure on entry to SEND_SUM.
    base = rx_cnt;
    push_cmd(32'd4);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK);
      if (comm_enq) seen = 1;
    end
    check("stall_cyc_enq", 32'(seen), 32'd1);
    check("stall_cyc_d", comm_d, 32'd6);
    @(posedge CLK);
    #1 comm_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("stall_enq_low", 32'(comm_enq), 32'd0);
      check("stall_d_stable", comm_d, 32'd6);
    end
    @(posedge CLK);
    #1 comm_full = 1'b0;
    @(negedge CLK);
    check("stall_sum_enq", 32'(comm_enq), 32'd1);
    check("stall_sum_d", comm_d, 32'd6);
    wait_rx("stall", base + 3, 50);
    check("stall_r0", rx[base], 32'd6);
    check("stall_r1", rx[base+1], 32'd6);
    check("stall_r2", rx[base+2], 32'd0);

    // Full address range, then an over-range command that clamps.
    do_cmd("n4096", 32'd4096, 0, 32'd4098, 32'd8386560, 32'd0, 6000);
    do_cmd("n5000", 32'd5000, 0, 32'd4098, 32'd8386560, 32'd0, 6000);

    // Corrupted word at address 2.
    mem[2] = 32'd99;
    do_cmd("bad2", 32'd4, 4, 32'd6, 32'd103, 32'd1, 100);
    mem[2] = 32'd2;

    // Asynchronous reset mid-READ at address 2 (comm_d currently holds 1).
    base = rx_cnt;
    push_cmd(32'd4);
    wait_deq("arst");
    repeat (4) @(negedge CLK);
    check("arst_pre_addr", 32'(mem_addr), 32'd2);
    #1 RST = 1'b1;
    #1;
    check("arst_mem_addr", 32'(mem_addr), 32'd0);
    check("arst_comm_d", comm_d, 32'd0);
    check("arst_comm_enq", 32'(comm_enq), 32'd0);
    check("arst_comm_deq", 32'(comm_deq), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (10) @(negedge CLK);
    check("arst_no_enq", 32'(rx_cnt), 32'(base));
    do_cmd("post_rst", 32'd4, 4, 32'd6, 32'd6, 32'd0, 100);

    check("no_deq_enq_overlap", 32'(overlap_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/memread_check_main.md
MEMREAD_CHECK_MAIN -- requirements
Module: memread_check_main

Interface
REQ-001 The module SHALL have parameter SIMD_WIDTH, default 1, giving the number of W_D-bit lanes per memory word.
REQ-002 The module SHALL have parameter W_D, default 32, giving the lane width.
REQ-003 The module SHALL have parameter W_A, default 12, giving the memory address width.
REQ-004 The module SHALL have parameter W_COMM_D, default 32, giving the channel data width.
REQ-005 The module SHALL have one clock, CLK, with all logic sampled on its rising edge.
REQ-006 The module SHALL have RST as its reset: asynchronous and active-high.
REQ-007 The module SHALL have the following ports, name / direction / width / meaning:
- CLK  in  1  clock.
- RST  in  1  async active-high reset.
- mem_addr  out  W_A  memory read address.
- mem_q  in  W_D*SIMD_WIDTH  read data for the previous cycle's mem_addr.
- comm_d  out  W_COMM_D  channel enqueue data.
- comm_enq  out  1  channel enqueue strobe.
- comm_full  in  1  channel full.
- comm_q  in  W_COMM_D  channel dequeue data, valid the cycle after comm_deq.
- comm_deq  out  1  channel dequeue strobe.
- comm_empty  in  1  channel empty.

Function
REQ-008 The FSM SHALL have the states IDLE, DEQ, LATCH, READ, DRAIN, SEND_CYC, SEND_SUM and SEND_ERR.
REQ-009 IDLE: if comm_empty=0, the FSM SHALL go to DEQ; otherwise it stays in IDLE.
REQ-010 DEQ: comm_deq SHALL be 1 for exactly this one cycle, then the FSM goes to LATCH.
REQ-011 LATCH: the FSM SHALL capture N = comm_q[W_A:0], clamping values above 2^W_A to 2^W_A.
REQ-012 LATCH: the FSM SHALL clear the read index, sum and error count, then go to READ if N>0 or to SEND_CYC if N=0.
REQ-013 READ: mem_addr SHALL equal the read index, which increments by 1 per cycle.
REQ-014 READ: after issuing address N-1, the FSM SHALL go to DRAIN.
REQ-015 Read latency SHALL be 1 cycle: the data for an address is accumulated in the cycle after that address is issued, with a valid flag piped alongside it.
REQ-016 DRAIN SHALL last one cycle, accumulate the last word, then go to SEND_CYC.
REQ-017 Sum: every valid word SHALL add the unsigned sum of all SIMD_WIDTH lanes, zero-extended or truncated to W_COMM_D, with modulo-2^W_COMM_D wrap-around.
REQ-018 Check: a valid word SHALL increment the error count when lane 0 differs from its address zero-extended to W_D.
REQ-019 The error count SHALL saturate at all-ones.
REQ-020 The cycle counter SHALL be cleared in IDLE.
REQ-021 The cycle counter SHALL increment by 1 in each LATCH, READ and DRAIN cycle and hold in all other states.
REQ-022 As a result, the reported cycle count SHALL be N+2 for N>=1 and 1 for N=0.
REQ-023 In each SEND_* state with comm_full=0, the FSM SHALL drive comm_enq=1 for one cycle with comm_d equal to, respectively, the cycle count, the sum, or the error count, and then advance.
REQ-024 SEND_CYC SHALL advance to SEND_SUM, SEND_SUM to SEND_ERR, and SEND_ERR to IDLE.
REQ-025 While comm_full=1, the FSM SHALL stay in its SEND_* state with comm_enq=0.
REQ-026 comm_d SHALL hold its last value whenever comm_enq=0.
REQ-027 comm_deq and comm_enq SHALL never be 1 in the same cycle, and each SHALL be a single-cycle pulse.
REQ-028 comm_empty SHALL be ignored in every state except IDLE, so new commands wait until the report completes.
REQ-029 mem_addr SHALL hold its value outside READ.
REQ-030 The module SHALL never write to memory.

Reset
REQ-031 RST=1 SHALL immediately, without waiting for a clock edge, force the state to IDLE.
REQ-032 RST=1 SHALL immediately clear mem_addr, comm_d, comm_enq, comm_deq, N, the read index, sum, error count, cycle counter and valid pipe to 0.
REQ-033 Asserting RST in any state, including mid-READ or mid-SEND, SHALL abort the operation with no further comm_enq, and the partial results SHALL be discarded.
REQ-034 After RST is released, the FSM SHALL begin at IDLE on the first rising edge of CLK.

Verification
REQ-035 With the memory model mem[a]={SIMD lanes = a}, SIMD_WIDTH=1, and N=4 enqueued: expect addresses 0,1,2,3 on consecutive cycles, then enqueues 6, 6, 0 in that order.
REQ-036 N=0: expect no memory reads, then enqueues 1, 0, 0.
REQ-037 Same as REQ-035 but mem[2]=99: expect enqueues 6, 103, 1.
REQ-038 N=4 with comm_full held at 1 for 5 cycles on entry to SEND_SUM: expect comm_enq=0 during the stall, then the sum 6 enqueued in the first cycle after comm_full falls, and comm_d stable throughout.
REQ-039 N=4096 (W_A=12), then a second command N=5000: expect 4096 reads with sum 8386560 and cycle count 4098; the second command clamps to 4096 and reports identically.
REQ-040 Assert RST asynchronously mid-READ at address 2: expect all outputs 0 with no clock edge, no enqueue, and a subsequent command N=4 producing 6, 6, 0.
